sha256d_header_feeder: RTL and testbench
========================================

# sha256d_header_feeder

Upstream stage of the SHA-256d core. It stores one 80-byte block header loaded byte-serially, serves it to the core as 32-bit words on request, and replaces header word 19 with an internal nonce counter. After every completed double hash it advances the nonce and restarts the core, sweeping the nonce space until the sweep is stopped or the counter is exhausted.

## Interface
No parameters; sizes are fixed.
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset, synchronous, active-high
- ld_valid  in  1  header byte strobe
- ld_data  in  8  header byte, sent in header order, byte 0 first
- ld_ready  out  1  high only in LOAD; bytes are accepted when ld_valid && ld_ready
- ld_clear  in  1  abort from any state; returns to LOAD and clears the byte count
- run  in  1  level; allows hashing to start or continue
- core_start  out  1  one-cycle start pulse to the core
- core_rq  in  1  core word request
- core_addr  in  5  requested word index, stable while core_rq is high
- core_data  out  32  requested word
- core_rdy  out  1  one-cycle strobe; core_data is valid in the same cycle
- core_done  in  1  one-cycle pulse from the core: double hash complete
- nonce  out  32  nonce of the hash now running, or of the hash that just completed when core_done is sampled
- busy  out  1  high in START and RUN
- exhausted  out  1  sticky; set when the hash with nonce 0xFFFFFFFF completes

## Operation
- Storage: 80 bytes hdr[0..79]. Word w = {hdr[4w], hdr[4w+1], hdr[4w+2], hdr[4w+3]}, so the lower byte index sits in the higher bits.
- Nonce register n[31:0]. After the 80th byte it holds {hdr[79], hdr[78], hdr[77], hdr[76]}, the little-endian header field. Word 19 is served as {n[7:0], n[15:8], n[23:16], n[31:24]}. hdr[76..79] are never read for serving.
- Words served by address:
  - addr 0–18: the stored header word.
  - addr 19: the nonce word.
  - addr 20–31: 32'h0 (the core applies its own padding).
- States:
  - LOAD: each accepted byte is written at the byte counter, then the counter increments. On the 80th byte → READY and the counter resets to 0.
  - READY: if run=1 → START.
  - START: core_start=1 for this one cycle → RUN.
  - RUN: serves requests. On core_done:
    - if n==32'hFFFFFFFF → DONE and exhausted<=1 (n is left unchanged).
    - otherwise n<=n+1, then → START if run=1, else → READY.
  - DONE: holds everything; only ld_clear or rst leaves it.
- ld_clear, from any state: → LOAD, byte counter=0, exhausted<=0, core_rdy<=0. Header bytes and n are kept until they are overwritten.
- Request service applies in RUN only:
  - A rising edge of core_rq (sampled 0 then 1) triggers exactly one response.
  - The core must drop core_rq for at least 1 cycle between requests.
  - Requests in any other state are ignored.
- Priority within one cycle: rst > ld_clear > core_done > core_rq. A request sampled in the same cycle as core_done gets no response.
- ld_valid outside LOAD is ignored. Bytes beyond 80 cannot occur, because ld_ready is already low.
- Width rule: n increments modulo 2^32, but it never wraps in operation because the all-ones value ends in DONE.

## Timing
- Reset values:
  - state LOAD, byte counter 0, n=0.
  - ld_ready=1, core_start=0, core_data=0, core_rdy=0, busy=0, exhausted=0.
- ld_ready is decoded combinationally from state. All other outputs are registered.
- Load: 80 accepted beats; READY is entered on the cycle after the 80th beat.
- READY→START→RUN: core_start is high in the cycle after run is sampled high in READY.
- Request latency: core_rq rise sampled at edge t → core_data/core_rdy valid after edge t+1, high for exactly 1 cycle. core_data holds its value until the next response.
- core_done at edge t:
  - n is updated at t+1.
  - With run=1, the next core_start is high during cycle t+1 to t+2. That gives back-to-back hashes one START cycle apart.
- rst or ld_clear during RUN: the in-flight hash is abandoned, no further core_rdy is issued, and a late core_done is ignored.

## Test plan
- Load bytes 0x00..0x4F, run=1, then request addr 0, 18, 19, 25:
  - addr 0 → 0x00010203.
  - addr 18 → 0x48494A4B.
  - addr 19 → 0x4C4D4E4F (n=0x4F4E4D4C).
  - addr 25 → 0x00000000.
  - Each core_rdy arrives exactly 1 cycle after the rq rise.
- Three core_done pulses with run=1: nonce steps 0x4F4E4D4C→…4D→…4E→…4F, the addr 19 word becomes 0x4F4D4E4F after the third pulse, and each core_start follows core_done by 1 cycle.
- Header bytes 76..79 = FF FF FF FF, then core_done: exhausted=1, DONE, nonce stays 0xFFFFFFFF, and no further core_start is issued.
- run=0 at core_done: → READY with n incremented and no core_start. Raising run then gives core_start 1 cycle later.
- core_done and a core_rq rise in the same cycle: no core_rdy. Holding core_rq high continuously: exactly one core_rdy.
- Mid-RUN tests:
  - ld_clear mid-RUN: ld_ready=1 and busy=0 next cycle, exhausted=0, and a following core_done has no effect.
  - rst mid-load at byte 40: ld_ready=1, 80 fresh bytes are needed, and all outputs are at reset values.

Source files
------------

// File: rtl/sha256d_header_feeder.sv
// Header feeder for the SHA-256d core: holds an 80-byte header, serves it as
// 32-bit words with word 19 replaced by a free-running nonce, and sweeps nonces.
module sha256d_header_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        ld_clear,
  input  logic        run,
  output logic        core_start,
  input  logic        core_rq,
  input  logic [4:0]  core_addr,
  output logic [31:0] core_data,
  output logic        core_rdy,
  input  logic        core_done,
  output logic [31:0] nonce,
  output logic        busy,
  output logic        exhausted
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_READY = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] n_q, n_d;
  logic [31:0] data_q, data_d;
  logic        start_q, start_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        exh_q, exh_d;
  logic        rq_prev_q;
  logic        rq_rise;
  logic [6:0]  base;
  logic [31:0] word_sel;

  // Bytes 76..79 live only in the nonce register, so storage stops at 75.
  logic [7:0]  hdr_q [0:75];

  assign ld_ready   = (state_q == S_LOAD);
  assign core_start = start_q;
  assign core_data  = data_q;
  assign core_rdy   = rdy_q;
  assign nonce      = n_q;
  assign busy       = busy_q;
  assign exhausted  = exh_q;

  assign rq_rise = core_rq && !rq_prev_q;
  assign base    = {core_addr, 2'b00};

  // Word selected by the requested address; lower byte index lands in higher bits.
  always_comb begin
    word_sel = 32'h0;
    if (core_addr < 5'd19) begin
      word_sel = {hdr_q[base], hdr_q[base + 7'd1], hdr_q[base + 7'd2], hdr_q[base + 7'd3]};
    end else if (core_addr == 5'd19) begin
      word_sel = {n_q[7:0], n_q[15:8], n_q[23:16], n_q[31:24]};
    end else begin
      word_sel = 32'h0;
    end
  end

  // Next-state and next-output logic; ld_clear outranks core_done, which outranks core_rq.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    exh_d   = exh_q;
    if (ld_clear) begin
      state_d = S_LOAD;
      cnt_d   = 7'd0;
      exh_d   = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (ld_valid) begin
            if (cnt_q >= 7'd76) begin
              case (cnt_q[1:0])
                2'd0:    n_d[7:0]   = ld_data;
                2'd1:    n_d[15:8]  = ld_data;
                2'd2:    n_d[23:16] = ld_data;
                2'd3:    n_d[31:24] = ld_data;
                default: n_d        = n_q;
              endcase
            end else begin
              n_d = n_q;
            end
            if (cnt_q == 7'd79) begin
              state_d = S_READY;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_READY: begin
          if (run) begin
            state_d = S_START;
          end else begin
            state_d = S_READY;
          end
        end
        S_START: state_d = S_RUN;
        S_RUN: begin
          if (core_done) begin
            if (n_q == 32'hFFFF_FFFF) begin
              state_d = S_DONE;
              exh_d   = 1'b1;
            end else begin
              n_d     = n_q + 32'd1;
              state_d = run ? S_START : S_READY;
            end
          end else if (rq_rise) begin
            rdy_d  = 1'b1;
            data_d = word_sel;
          end else begin
            rdy_d = 1'b0;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_LOAD;
      endcase
    end
    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_RUN);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      cnt_q     <= 7'd0;
      n_q       <= 32'h0;
      data_q    <= 32'h0;
      start_q   <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      exh_q     <= 1'b0;
      rq_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      data_q    <= data_d;
      start_q   <= start_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      exh_q     <= exh_d;
      rq_prev_q <= core_rq;
    end
  end

  // Header byte storage; contents survive reset and clear until overwritten.
  always_ff @(posedge clk) begin
    if (!rst && !ld_clear && (state_q == S_LOAD) && ld_valid && (cnt_q < 7'd76)) begin
      hdr_q[cnt_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_sha256d_header_feeder.sv
// Directed self-checking bench for sha256d_header_feeder.
module tb_sha256d_header_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_clear;
  logic        run;
  logic        core_start;
  logic        core_rq;
  logic [4:0]  core_addr;
  logic [31:0] core_data;
  logic        core_rdy;
  logic        core_done;
  logic [31:0] nonce;
  logic        busy;
  logic        exhausted;

  int checks = 0;
  int errors = 0;

  sha256d_header_feeder dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_clear(ld_clear), .run(run), .core_start(core_start), .core_rq(core_rq),
    .core_addr(core_addr), .core_data(core_data), .core_rdy(core_rdy),
    .core_done(core_done), .nonce(nonce), .busy(busy), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes 0..75 carry their own index; bytes 76..79 come from tail (byte 76 in tail[31:24]).
  task automatic load_bytes(input int count, input logic [31:0] tail);
    logic [31:0] sh;
    for (int i = 0; i < count; i++) begin
      ld_valid = 1'b1;
      if (i < 76) begin
        ld_data = 8'(i);
      end else begin
        sh = tail >> (8 * (79 - i));
        ld_data = sh[7:0];
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = 8'h00;
  endtask

  task automatic request(input logic [4:0] a, output logic rdy1, output logic [31:0] d1,
                         output logic rdy2);
    core_rq   = 1'b1;
    core_addr = a;
    tick();
    rdy1 = core_rdy;
    d1   = core_data;
    core_rq = 1'b0;
    tick();
    rdy2 = core_rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; ld_clear = 1'b0; run = 1'b0;
    core_rq = 1'b0; core_addr = 5'd0; core_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({ld_ready, core_start, core_rdy, busy, exhausted} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 10000", {ld_ready, core_start, core_rdy, busy, exhausted});
    end
    checks++;
    if (core_data !== 32'h0 || nonce !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got data=%h nonce=%h expected 0/0", core_data, nonce);
    end
  endtask

  task automatic test_load_and_serve();
    logic [4:0]  addrs [4];
    logic [31:0] exp   [4];
    logic r1, r2;
    logic [31:0] d;
    addrs = '{5'd0, 5'd18, 5'd19, 5'd25};
    exp   = '{32'h00010203, 32'h48494A4B, 32'h4C4D4E4F, 32'h00000000};
    load_bytes(80, 32'h4C4D4E4F);
    checks++;
    if (ld_ready !== 1'b0 || nonce !== 32'h4F4E4D4C) begin
      errors++;
      $display("FAIL load_done got ld_ready=%b nonce=%h expected 0/4f4e4d4c", ld_ready, nonce);
    end
    run = 1'b1;
    tick();
    checks++;
    if (core_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start got start=%b busy=%b expected 1/1", core_start, busy);
    end
    tick();
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse_width got %b expected 0", core_start);
    end
    for (int k = 0; k < 4; k++) begin
      request(addrs[k], r1, d, r2);
      checks++;
      if (r1 !== 1'b1 || d !== exp[k] || r2 !== 1'b0) begin
        errors++;
        $display("FAIL serve_addr%0d got rdy=%b data=%h rdy_next=%b expected 1/%h/0",
                 addrs[k], r1, d, r2, exp[k]);
      end
    end
  endtask

  task automatic test_nonce_advance();
    logic r1, r2;
    logic [31:0] d;
    for (int k = 1; k <= 3; k++) begin
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      checks++;
      if (core_start !== 1'b1 || nonce !== 32'h4F4E4D4C + 32'(k)) begin
        errors++;
        $display("FAIL advance%0d got start=%b nonce=%h expected 1/%h", k, core_start, nonce,
                 32'h4F4E4D4C + 32'(k));
      end
      tick();
    end
    request(5'd19, r1, d, r2);
    checks++;
    if (r1 !== 1'b1 || d !== 32'h4F4D4E4F) begin
      errors++;
      $display("FAIL nonce_word got rdy=%b data=%h expected 1/4f4d4e4f", r1, d);
    end
  endtask

  task automatic test_done_rq_collision();
    int pulses;
    core_done = 1'b1;
    core_rq   = 1'b1;
    core_addr = 5'd0;
    tick();
    core_done = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (core_rdy === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL done_rq_same_cycle got %0d rdy pulses expected 0", pulses);
    end
    core_rq = 1'b0;
    tick();
    core_rq = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (core_rdy === 1'b1) pulses++;
    end
    core_rq = 1'b0;
    tick();
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL rq_held_high got %0d rdy pulses expected 1", pulses);
    end
  endtask

  task automatic test_run_low();
    run = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if (core_start !== 1'b0 || busy !== 1'b0 || nonce !== 32'h4F4E4D51) begin
      errors++;
      $display("FAIL run_low_done got start=%b busy=%b nonce=%h expected 0/0/4f4e4d51",
               core_start, busy, nonce);
    end
    tick(); tick();
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("FAIL run_low_idle got start=%b expected 0", core_start);
    end
    run = 1'b1;
    tick();
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL run_raise_start got start=%b expected 1", core_start);
    end
    tick();
  endtask

  task automatic test_clear_mid_run();
    logic r1, r2;
    logic [31:0] d;
    ld_clear = 1'b1;
    tick();
    ld_clear = 1'b0;
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0 || exhausted !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_run got ld_ready=%b busy=%b exh=%b expected 1/0/0",
               ld_ready, busy, exhausted);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if (nonce !== 32'h4F4E4D51 || core_start !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_done got nonce=%h start=%b ld_ready=%b expected 4f4e4d51/0/1",
               nonce, core_start, ld_ready);
    end
    request(5'd0, r1, d, r2);
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL rq_in_load got rdy=%b,%b expected 0,0", r1, r2);
    end
  endtask

  task automatic test_exhaust();
    logic r1, r2;
    logic [31:0] d;
    int starts;
    load_bytes(80, 32'hFFFFFFFF);
    tick();
    tick();
    request(5'd19, r1, d, r2);
    checks++;
    if (r1 !== 1'b1 || d !== 32'hFFFFFFFF || nonce !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL exhaust_word got rdy=%b data=%h nonce=%h expected 1/ffffffff/ffffffff",
               r1, d, nonce);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if (exhausted !== 1'b1 || nonce !== 32'hFFFFFFFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL exhaust got exh=%b nonce=%h busy=%b expected 1/ffffffff/0",
               exhausted, nonce, busy);
    end
    starts = 0;
    for (int k = 0; k < 5; k++) begin
      if (core_start === 1'b1) starts++;
      tick();
    end
    request(5'd0, r1, d, r2);
    checks++;
    if (starts !== 0 || r1 !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got starts=%0d rdy=%b ld_ready=%b expected 0/0/0",
               starts, r1, ld_ready);
    end
    ld_clear = 1'b1;
    tick();
    ld_clear = 1'b0;
    checks++;
    if (exhausted !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_clear got exh=%b ld_ready=%b expected 0/1", exhausted, ld_ready);
    end
  endtask

  task automatic test_rst_mid_load();
    logic r1, r2;
    logic [31:0] d;
    load_bytes(40, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ld_ready, core_start, core_rdy, busy, exhausted} !== 5'b10000 ||
        core_data !== 32'h0 || nonce !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_load got flags=%b data=%h nonce=%h expected 10000/0/0",
               {ld_ready, core_start, core_rdy, busy, exhausted}, core_data, nonce);
    end
    load_bytes(79, 32'h01020304);
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL fresh_79 got ld_ready=%b expected 1", ld_ready);
    end
    ld_valid = 1'b1;
    ld_data  = 8'h04;
    tick();
    ld_valid = 1'b0;
    checks++;
    if (ld_ready !== 1'b0 || nonce !== 32'h04030201) begin
      errors++;
      $display("FAIL fresh_80 got ld_ready=%b nonce=%h expected 0/04030201", ld_ready, nonce);
    end
    tick();
    tick();
    request(5'd10, r1, d, r2);
    checks++;
    if (r1 !== 1'b1 || d !== 32'h28292A2B) begin
      errors++;
      $display("FAIL fresh_serve got rdy=%b data=%h expected 1/28292a2b", r1, d);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_serve();
    test_nonce_advance();
    test_done_rq_collision();
    test_run_low();
    test_clear_mid_run();
    test_exhaust();
    test_rst_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
